cache_fill_fsm: RTL and testbench

- Miss handler for the direct-mapped cache: 128 blocks × 8 words, 16-bit words, tag = address[15:11], index = address[10:4], word offset = address[3:1].
- On a cache miss it fetches the whole 8-word block from pipelined main memory.
- It writes each returned word into the data array, then writes the tag into the metadata array.
- Sits between the cache and memory. Drives the cache's data_write/tag_write strobes and the address the cache decodes during a fill.

---
 rtl/cache_fill_fsm.sv | 171 +++++++++++++++++
 tb/tb_cache_fill_fsm.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - miss handler that fills one cache block from pipelined memory
//
// Purpose:
//   On a cache miss, fetches every word of the missing block from main memory.
//   Each returned word is written into the cache data array as it arrives.
//   The tag is written in one final cycle, and the block then becomes valid.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   miss_detected       cache miss indication, sampled only while idle
//   miss_address        byte address that missed; low block-offset bits ignored
//   fsm_busy            fill in progress (pipeline stall)
//   memory_read         one-cycle read request to main memory
//   memory_address      request address, 0 when memory_read is low
//   memory_data_valid   one returned word this cycle (in request order)
//   memory_data         returned word
//   write_data_array    data_write strobe to the cache
//   write_tag_array     tag_write strobe to the cache
//   cache_address       address decoded by the cache during a fill
//   fill_data           data_in to the cache, straight from memory_data

module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8    // power of two, at least 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fsm_busy,
  output logic                  memory_read,
  output logic [ADDR_WIDTH-1:0] memory_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [ADDR_WIDTH-1:0] cache_address,
  output logic [15:0]           fill_data
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = CNT_W + 1;  // byte offset within a block
  localparam logic [CNT_W-1:0]      LAST_WORD  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CNT_W-1:0]        req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]        rcv_cnt_q, rcv_cnt_d;
  logic                    busy_q, busy_d;
  logic                    read_q, read_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    tag_q, tag_d;

  logic                    rsp_write;
  logic [CNT_W-1:0]        req_next;

  // base has its offset bits cleared, so OR-ing the word offset in never
  // carries into the index or tag.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] b,
                                                      input logic [CNT_W-1:0]      w);
    return b | ADDR_WIDTH'({w, 1'b0});
  endfunction

  always_comb begin
    rsp_write  = (state_q == FILL) && memory_data_valid;
    req_next   = req_cnt_q + CNT_W'(1);

    state_d    = state_q;
    base_d     = base_q;
    req_cnt_d  = req_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    busy_d     = busy_q;
    read_d     = 1'b0;
    mem_addr_d = '0;
    tag_d      = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (miss_detected) begin
          state_d    = FILL;
          base_d     = miss_address & BLOCK_MASK;
          req_cnt_d  = '0;
          rcv_cnt_d  = '0;
          busy_d     = 1'b1;
          read_d     = 1'b1;
          mem_addr_d = miss_address & BLOCK_MASK;
        end
      end

      FILL: begin
        // read_q marks a request going out this cycle; the next one is
        // prepared unless this was the last word of the block.
        if (read_q) begin
          req_cnt_d = req_next;
          if (req_cnt_q != LAST_WORD) begin
            read_d     = 1'b1;
            mem_addr_d = word_addr(base_q, req_next);
          end
        end
        if (rsp_write) begin
          rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
          if (rcv_cnt_q == LAST_WORD) begin
            state_d    = TAG;
            tag_d      = 1'b1;
            read_d     = 1'b0;
            mem_addr_d = '0;
          end
        end
      end

      TAG: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      req_cnt_q  <= '0;
      rcv_cnt_q  <= '0;
      busy_q     <= 1'b0;
      read_q     <= 1'b0;
      mem_addr_q <= '0;
      tag_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      req_cnt_q  <= req_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      busy_q     <= busy_d;
      read_q     <= read_d;
      mem_addr_q <= mem_addr_d;
      tag_q      <= tag_d;
    end
  end

  assign fsm_busy         = busy_q;
  assign memory_read      = read_q;
  assign memory_address   = mem_addr_q;
  assign write_tag_array  = tag_q;
  // The data strobe must land in the same cycle as the returned word, so it
  // is decoded from the registered state and the live valid.
  assign write_data_array = rsp_write;
  assign fill_data        = memory_data;

  always_comb begin
    cache_address = '0;
    if (rsp_write) begin
      cache_address = word_addr(base_q, rcv_cnt_q);
    end else if (state_q != IDLE) begin
      cache_address = base_q;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - randomized self-checking bench for cache_fill_fsm

module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_address;
  logic [15:0] fill_data;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .fsm_busy         (fsm_busy),
    .memory_read      (memory_read),
    .memory_address   (memory_address),
    .memory_data_valid(memory_data_valid),
    .memory_data      (memory_data),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .cache_address    (cache_address),
    .fill_data        (fill_data)
  );

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
  } rsp_t;

  rsp_t        memq[$];
  int          cyc;
  int          lat;
  int          checks;
  int          errors;
  int          b_lo = 1;
  int          b_hi = 0;
  logic [15:0] m_base;
  int          acc_cnt;
  int          wr_seen;
  int          tag_seen;
  int          fills_exp;
  bit          stray_en;
  logic [15:0] rsp_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit busy_at(input int c);
    return (c >= b_lo) && (c <= b_hi);
  endfunction

  // Reference: a fill accepted in cycle c0 is busy c0+1 .. c0+9+L, requests
  // words 0..7 in c0+1 .. c0+8, writes during the fill whenever a word returns,
  // and writes the tag in its last busy cycle.
  task automatic sample();
    bit          busy_e, rd_e, wr_e, tag_e;
    logic [15:0] ra_e, ca_e;
    busy_e = busy_at(cyc);
    rd_e   = busy_e && (cyc <= b_lo + 7);
    ra_e   = rd_e ? m_base + 16'(2 * (cyc - b_lo)) : 16'h0;
    wr_e   = memory_data_valid && busy_e && (cyc < b_hi);
    tag_e  = busy_e && (cyc == b_hi);
    ca_e   = wr_e ? rsp_addr : (busy_e ? m_base : 16'h0);
    check_eq("fsm_busy", fsm_busy, busy_e);
    check_eq("memory_read", memory_read, rd_e);
    check_eq("memory_address", memory_address, ra_e);
    check_eq("write_data_array", write_data_array, wr_e);
    check_eq("write_tag_array", write_tag_array, tag_e);
    check_eq("cache_address", cache_address, ca_e);
    check_eq("fill_data", fill_data, memory_data);
    if (write_data_array) wr_seen++;
    if (write_tag_array) tag_seen++;
    if (tag_e) fills_exp++;
    if (memory_read) memq.push_back('{cyc + lat, memory_address, 16'($urandom)});
    if (rst_n && miss_detected && !busy_e) begin
      m_base = miss_address & 16'hFFF0;
      b_lo   = cyc + 1;
      b_hi   = cyc + 9 + lat;
      acc_cnt++;
    end
  endtask

  task automatic drive_mem();
    memory_data       = 16'($urandom);
    memory_data_valid = 1'b0;
    if (memq.size() > 0 && memq[0].due == cyc) begin
      rsp_t r;
      r = memq.pop_front();
      memory_data_valid = 1'b1;
      memory_data       = r.data;
      rsp_addr          = r.addr;
    end else if (stray_en && (cyc == b_hi || (!busy_at(cyc) && $urandom_range(0, 2) == 0))) begin
      memory_data_valid = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic wait_accept(input int budget);
    int start;
    int n;
    start = acc_cnt;
    n = 0;
    while (acc_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check_eq("miss_accept", acc_cnt - start, 1);
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while ((cyc <= b_hi || memq.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check_eq("settle_timeout", (cyc <= b_hi || memq.size() > 0), 0);
    tick();
  endtask

  task automatic start_fill(input logic [15:0] addr);
    miss_detected = 1'b1;
    miss_address  = addr;
    wait_accept(40);
    miss_detected = 1'b0;
    miss_address  = 16'($urandom);
  endtask

  task automatic abort_fill();
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", fsm_busy, 0);
    check_eq("rst_read", memory_read, 0);
    check_eq("rst_maddr", memory_address, 0);
    check_eq("rst_wdata", write_data_array, 0);
    check_eq("rst_wtag", write_tag_array, 0);
    check_eq("rst_caddr", cache_address, 0);
    b_lo = 1;
    b_hi = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w0, t0;
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data_valid = 1'b1;
    memory_data       = 16'h5A5A;
    lat               = 4;
    #2;
    check_eq("reset_busy", fsm_busy, 0);
    check_eq("reset_read", memory_read, 0);
    check_eq("reset_maddr", memory_address, 0);
    check_eq("reset_wdata", write_data_array, 0);
    check_eq("reset_wtag", write_tag_array, 0);
    check_eq("reset_caddr", cache_address, 0);
    check_eq("reset_fill_data", fill_data, 16'h5A5A);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    drive_mem();
    tick();

    lat = 4;
    start_fill(16'h1236);
    settle(100);

    lat = 1;
    start_fill(16'hF7F0);
    settle(100);

    lat = 3;
    start_fill(16'h0800);
    repeat (3) tick();
    miss_detected = 1'b1;
    miss_address  = 16'h0040;
    wait_accept(60);
    miss_detected = 1'b0;
    settle(100);

    lat = 2;
    start_fill(16'h4A16);
    w0 = wr_seen;
    for (int n = 0; n < 60 && (wr_seen - w0) < 3; n++) tick();
    check_eq("pre_abort_writes", wr_seen - w0, 3);
    t0 = tag_seen;
    abort_fill();
    settle(60);
    check_eq("abort_no_tag", tag_seen - t0, 0);

    stray_en = 1'b1;
    lat = 3;
    start_fill(16'h7778);
    settle(100);
    repeat (6) tick();
    stray_en = 1'b0;

    lat = 2;
    w0 = wr_seen;
    t0 = tag_seen;
    miss_detected = 1'b1;
    miss_address  = 16'h1230;
    wait_accept(10);
    miss_address  = 16'h2230;
    wait_accept(40);
    miss_detected = 1'b0;
    settle(100);
    check_eq("b2b_data_writes", wr_seen - w0, 16);
    check_eq("b2b_tag_writes", tag_seen - t0, 2);

    for (int e = 0; e < 25; e++) begin
      lat      = $urandom_range(1, 6);
      stray_en = ($urandom_range(0, 1) == 1);
      start_fill(16'($urandom));
      case ($urandom_range(0, 3))
        0: begin
          repeat ($urandom_range(1, 6)) tick();
          miss_detected = 1'b1;
          miss_address  = 16'($urandom);
          wait_accept(60);
          miss_detected = 1'b0;
        end
        1: begin
          repeat ($urandom_range(1, 8)) tick();
          abort_fill();
        end
        default: ;
      endcase
      settle(200);
    end
    stray_en = 1'b0;
    tick();
    check_eq("tag_total", tag_seen, fills_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
